mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the byte-address and word-index width.
REQ-003 SHALL have parameter MEM_DEPTH, default 100, meaning the number of words in the data memory.
REQ-004 SHALL have port CLK, input, 1 bit, the clock.
REQ-005 SHALL have port RST, input, 1 bit, the reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1 bit, meaning a core access request is present.
REQ-007 SHALL have port req_ready, output, 1 bit, meaning the unit accepts a request.
REQ-008 SHALL have port req_op, input, 3 bits, with 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH bits, the byte address.
REQ-010 SHALL have port req_wdata, input, DATA_WIDTH bits, the store data (right-aligned for SB/SH).
REQ-011 SHALL have port rsp_valid, output, 1 bit, meaning a response is present.
REQ-012 SHALL have port rsp_ready, input, 1 bit, meaning the core accepts the response.
REQ-013 SHALL have port rsp_rdata, output, DATA_WIDTH bits, the extended load result.
REQ-014 SHALL have port rsp_err, output, 1 bit, meaning a misaligned or out-of-range access.
REQ-015 SHALL have port mem_a, output, ADDR_WIDTH bits, the memory word index (byte address >> 2).
REQ-016 SHALL have port mem_wd, output, DATA_WIDTH bits, the memory write data.
REQ-017 SHALL have port mem_we, output, 1 bit, the memory write enable (memory samples on the CLK rising edge).
REQ-018 SHALL have port mem_rd, input, DATA_WIDTH bits, the combinational memory read data for mem_a.

Function
REQ-019 SHALL implement an FSM with states IDLE, READ, WRITE and RESP.
REQ-020 SHALL drive req_ready=1 only in IDLE; a handshake (req_valid & req_ready) latches op, addr and wdata.
REQ-021 SHALL flag an error when LH/LHU/SH has addr[0]=1, when LW/SW has addr[1:0]≠0, or when addr>>2 ≥ MEM_DEPTH.
REQ-022 SHALL, on an accepted request, move IDLE→RESP if it errors, IDLE→WRITE for SW, and IDLE→READ otherwise.
REQ-023 SHALL, in READ, drive mem_a and register mem_rd; for loads it moves to RESP, for SB/SH it moves to WRITE.
REQ-024 SHALL, in WRITE, assert mem_we=1 for exactly one cycle with mem_wd equal to the full word (SW) or the merged word (SB/SH), then move to RESP.
REQ-025 SHALL use little-endian lanes: byte k = bits[8k+7:8k] with k=addr[1:0], and halfword h = bits[16h+15:16h] with h=addr[1].
REQ-026 SHALL make a SB/SH merge replace only the addressed lane of the word read in READ; all other bytes are unchanged.
REQ-027 SHALL sign-extend LB/LH results, zero-extend LBU/LHU results, and return LW results unmodified.
REQ-028 SHALL, in RESP, hold rsp_valid=1 and stable rsp_rdata/rsp_err until rsp_ready, then return to IDLE; the next request is accepted no earlier than the following cycle.
REQ-029 SHALL return rsp_rdata=0 for stores and for any error response.
REQ-030 SHALL never assert mem_we for an errored request.
REQ-031 SHALL hold mem_we=0 and mem_wd=0 outside WRITE, and hold mem_a at the latched word index (0 in IDLE).
REQ-032 SHALL meet these latencies from the acceptance edge T to rsp_valid: error T+1, SW T+2, load T+2, SB/SH T+3.
REQ-033 SHALL derive all outputs from registered state and latched data only (Moore); there is no combinational path from req_* to mem_*.

Reset
REQ-034 SHALL, while RST=0, force state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_a=0, mem_wd=0 and mem_we=0.
REQ-035 SHALL make req_ready=1 on the first CLK edge after RST deasserts.
REQ-036 SHALL treat a reset asserted mid-operation (READ or WRITE) as an abort: mem_we drops immediately, no response is produced, and the partial access is lost.

Structure
REQ-037 SHALL place the op encoding, the FSM state encoding and the width constants in shared package mem_access_pkg.
REQ-038 SHALL implement lane extraction/extension and store merging as one combinational sub-module, mem_lane_align.

Verification
REQ-039 SHALL verify SW addr 0x8 wdata 0xDEADBEEF: mem_we for one cycle at mem_a=2 with mem_wd 0xDEADBEEF, then rsp_valid at T+2 with rdata 0 and err 0.
REQ-040 SHALL verify, with word 2=0xDEADBEEF, that LB 0x9 returns 0xFFFFFFBE, LBU 0x9 returns 0x000000BE, and LH 0xA returns 0xFFFFDEAD, each at T+2.
REQ-041 SHALL verify SB addr 0xB wdata 0x11 on word 2=0xDEADBEEF: READ then WRITE with mem_wd 0x11ADBEEF, rsp at T+3, and a subsequent LW 0x8 returning 0x11ADBEEF.
REQ-042 SHALL verify that LW 0x6, SH 0x3 and LW 400 (index 100) each give rsp_err=1 at T+1, never assert mem_we, and return rdata 0.
REQ-043 SHALL verify that rsp_ready held 0 for 5 cycles keeps rsp_valid and rsp_rdata stable with req_ready=0; after rsp_ready=1 the unit is IDLE the next cycle.
REQ-044 SHALL verify that RST pulsed low during WRITE of SB forces mem_we=0 immediately, leaves the memory word unchanged, and produces no response.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: op and FSM encodings plus lane width constants shared by the load/store unit.
package mem_access_pkg;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    function automatic logic is_store(op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extraction/extension for loads and lane merging for stores.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  op_e                   op_i,
    input  logic [1:0]            off_i,
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] load_o,
    output logic [DATA_WIDTH-1:0] store_o
);
    logic [BYTE_W-1:0] b;
    logic [HALF_W-1:0] h;

    assign b = word_i[{off_i, 3'b000} +: BYTE_W];
    assign h = word_i[{off_i[1], 4'b0000} +: HALF_W];

    always_comb begin
        load_o = op_i == OP_LB  ? {{(DATA_WIDTH-BYTE_W){b[BYTE_W-1]}}, b} :
                 op_i == OP_LBU ? {{(DATA_WIDTH-BYTE_W){1'b0}}, b} :
                 op_i == OP_LH  ? {{(DATA_WIDTH-HALF_W){h[HALF_W-1]}}, h} :
                 op_i == OP_LHU ? {{(DATA_WIDTH-HALF_W){1'b0}}, h} : word_i;
    end

    // Sub-word stores keep every lane of the read word except the addressed one.
    always_comb begin
        store_o = op_i == OP_SW ? wdata_i : word_i;
        if (op_i == OP_SB)
            store_o[{off_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
        else if (op_i == OP_SH)
            store_o[{off_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: Moore FSM turning core load/store requests into single-word memory accesses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 100
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OP_W-1:0]       req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
);
    state_e                state_q, state_d;
    op_e                   op_q, op_d, req_op_e;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, word_q, word_d, load_w, store_w;
    logic                  err_q, err_d, live_q, req_err;

    assign req_op_e = op_e'(req_op);
    assign req_err  = (req_addr >> 2) >= ADDR_WIDTH'(MEM_DEPTH)
                   || (req_op_e inside {OP_LH, OP_LHU, OP_SH} && req_addr[0])
                   || (req_op_e inside {OP_LW, OP_SW} && |req_addr[1:0]);

    mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .op_i    (op_q),
        .off_i   (off_q),
        .word_i  (word_q),
        .wdata_i (wdata_q),
        .load_o  (load_w),
        .store_o (store_w)
    );

    // live_q holds req_ready low until the first edge after reset release.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            op_q    <= OP_LB;
            idx_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req_valid && live_q) begin
                op_d    = req_op_e;
                idx_d   = req_addr >> 2;
                off_d   = req_addr[1:0];
                wdata_d = req_wdata;
                err_d   = req_err;
                state_d = req_err ? S_RESP : req_op_e == OP_SW ? S_WRITE : S_READ;
            end
            S_READ: begin
                word_d  = mem_rd;
                state_d = is_store(op_q) ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            default: state_d = rsp_ready ? S_IDLE : S_RESP;
        endcase
    end

    always_comb begin
        req_ready = state_q == S_IDLE && live_q;
        rsp_valid = state_q == S_RESP;
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = rsp_valid && !err_q && !is_store(op_q) ? load_w : '0;
        mem_a     = state_q == S_IDLE ? '0 : idx_q;
        mem_we    = state_q == S_WRITE;
        mem_wd    = mem_we ? store_w : '0;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scenario tests of mem_access_unit against a small word memory.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        CLK, RST;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, mem_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, rsp_rdata, mem_a, mem_wd, mem_rd;
    logic [31:0] mem [100];
    logic        init_mem;
    int          passed, total;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(100)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign mem_rd = mem_a < 32'd100 ? mem[mem_a[6:0]] : 32'h0;

    always @(posedge CLK) begin
        if (init_mem) begin
            for (int i = 0; i < 100; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h01234567;
            mem[1] <= 32'hCAFEF00D;
        end else if (mem_we && mem_a < 32'd100)
            mem[mem_a[6:0]] <= mem_wd;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one request, waits (bounded) for the response and accepts it.
    // lat counts edges from acceptance to the edge at which rsp_valid is sampled high.
    task automatic run(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output int we_cnt, output logic [31:0] we_a, output logic [31:0] we_wd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        lat = 1;
        we_cnt = 0;
        we_a = 32'h0;
        we_wd = 32'h0;
        while (!rsp_valid && lat < 20) begin
            if (mem_we) begin
                we_cnt++;
                we_a = mem_a;
                we_wd = mem_wd;
            end
            tick();
            lat++;
        end
        rdata = rsp_rdata;
        err = rsp_err;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        init_mem = 1'b1;
        req_valid = 1'b0;
        req_op = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        init_mem = 1'b0;
        total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %b want 0", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
        total++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) $display("FAIL reset_rsp got %h/%b want 0/0", rsp_rdata, rsp_err); else passed++;
        total++; if (mem_we !== 1'b0 || mem_a !== 32'h0 || mem_wd !== 32'h0) $display("FAIL reset_mem got we=%b a=%h wd=%h want 0", mem_we, mem_a, mem_wd); else passed++;
        RST = 1'b1;
        #1;
        total++; if (req_ready !== 1'b0) $display("FAIL release_ready_early got %b want 0", req_ready); else passed++;
        tick();
        total++; if (req_ready !== 1'b1) $display("FAIL release_ready got %b want 1", req_ready); else passed++;
    endtask

    task automatic test_sw();
        int lat, we_cnt;
        logic [31:0] rd, wa, wd;
        logic err;
        run(3'd7, 32'h8, 32'hDEADBEEF, lat, rd, err, we_cnt, wa, wd);
        total++; if (lat !== 2) $display("FAIL sw_latency got %0d want 2", lat); else passed++;
        total++; if (we_cnt !== 1) $display("FAIL sw_we_cycles got %0d want 1", we_cnt); else passed++;
        total++; if (wa !== 32'd2) $display("FAIL sw_mem_a got %h want 2", wa); else passed++;
        total++; if (wd !== 32'hDEADBEEF) $display("FAIL sw_mem_wd got %h want deadbeef", wd); else passed++;
        total++; if (rd !== 32'h0 || err !== 1'b0) $display("FAIL sw_rsp got %h/%b want 0/0", rd, err); else passed++;
        total++; if (mem[2] !== 32'hDEADBEEF) $display("FAIL sw_mem_word got %h want deadbeef", mem[2]); else passed++;
        total++; if (req_ready !== 1'b1 || mem_a !== 32'h0) $display("FAIL sw_idle got rdy=%b a=%h want 1/0", req_ready, mem_a); else passed++;
    endtask

    task automatic test_loads();
        logic [2:0]  ops  [5] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd2};
        logic [31:0] adrs [5] = '{32'h9, 32'h9, 32'hA, 32'hA, 32'h8};
        logic [31:0] exps [5] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hDEADBEEF};
        for (int i = 0; i < 5; i++) begin
            int lat, we_cnt;
            logic [31:0] rd, wa, wd;
            logic err;
            run(ops[i], adrs[i], 32'h0, lat, rd, err, we_cnt, wa, wd);
            total++; if (rd !== exps[i] || err !== 1'b0) $display("FAIL load%0d_rdata got %h/%b want %h/0", i, rd, err, exps[i]); else passed++;
            total++; if (lat !== 2 || we_cnt !== 0) $display("FAIL load%0d_timing got lat=%0d we=%0d want 2/0", i, lat, we_cnt); else passed++;
        end
    endtask

    task automatic test_subword_store();
        int lat, we_cnt;
        logic [31:0] rd, wa, wd;
        logic err;
        run(3'd5, 32'hB, 32'h00000011, lat, rd, err, we_cnt, wa, wd);
        total++; if (lat !== 3) $display("FAIL sb_latency got %0d want 3", lat); else passed++;
        total++; if (we_cnt !== 1 || wa !== 32'd2) $display("FAIL sb_write got we=%0d a=%h want 1/2", we_cnt, wa); else passed++;
        total++; if (wd !== 32'h11ADBEEF) $display("FAIL sb_merge got %h want 11adbeef", wd); else passed++;
        total++; if (rd !== 32'h0 || err !== 1'b0) $display("FAIL sb_rsp got %h/%b want 0/0", rd, err); else passed++;
        run(3'd2, 32'h8, 32'h0, lat, rd, err, we_cnt, wa, wd);
        total++; if (rd !== 32'h11ADBEEF) $display("FAIL sb_readback got %h want 11adbeef", rd); else passed++;
        run(3'd6, 32'h4, 32'hFFFF1234, lat, rd, err, we_cnt, wa, wd);
        total++; if (wd !== 32'hCAFE1234 || we_cnt !== 1) $display("FAIL sh_merge got %h we=%0d want cafe1234/1", wd, we_cnt); else passed++;
        run(3'd6, 32'h6, 32'h0000ABCD, lat, rd, err, we_cnt, wa, wd);
        total++; if (wd !== 32'hABCD1234 || lat !== 3) $display("FAIL sh_upper got %h lat=%0d want abcd1234/3", wd, lat); else passed++;
    endtask

    task automatic test_errors();
        logic [2:0]  ops  [3] = '{3'd2, 3'd6, 3'd2};
        logic [31:0] adrs [3] = '{32'h6, 32'h3, 32'd400};
        for (int i = 0; i < 3; i++) begin
            int lat, we_cnt;
            logic [31:0] rd, wa, wd;
            logic err;
            run(ops[i], adrs[i], 32'hFFFFFFFF, lat, rd, err, we_cnt, wa, wd);
            total++; if (err !== 1'b1) $display("FAIL err%0d_flag got %b want 1", i, err); else passed++;
            total++; if (lat !== 1) $display("FAIL err%0d_latency got %0d want 1", i, lat); else passed++;
            total++; if (we_cnt !== 0) $display("FAIL err%0d_we got %0d want 0", i, we_cnt); else passed++;
            total++; if (rd !== 32'h0) $display("FAIL err%0d_rdata got %h want 0", i, rd); else passed++;
        end
        total++; if (mem[0] !== 32'h01234567) $display("FAIL err_mem0 got %h want 01234567", mem[0]); else passed++;
    endtask

    task automatic test_stall();
        int n;
        req_valid = 1'b1;
        req_op = 3'd2;
        req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        total++; if (rsp_valid !== 1'b1) $display("FAIL stall_rsp_timeout got %b want 1", rsp_valid); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) $display("FAIL stall%0d_hs got v=%b r=%b want 1/0", i, rsp_valid, req_ready); else passed++;
            total++; if (rsp_rdata !== 32'h11ADBEEF) $display("FAIL stall%0d_rdata got %h want 11adbeef", i, rsp_rdata); else passed++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL stall_release got r=%b v=%b want 1/0", req_ready, rsp_valid); else passed++;
    endtask

    task automatic test_reset_abort();
        req_valid = 1'b1;
        req_op = 3'd5;
        req_addr = 32'h0;
        req_wdata = 32'h00000055;
        tick();
        req_valid = 1'b0;
        tick();
        total++; if (mem_we !== 1'b1 || mem_wd !== 32'h01234555) $display("FAIL abort_write got we=%b wd=%h want 1/01234555", mem_we, mem_wd); else passed++;
        RST = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0 || mem_wd !== 32'h0) $display("FAIL abort_we got we=%b wd=%h want 0/0", mem_we, mem_wd); else passed++;
        tick();
        RST = 1'b1;
        total++; if (mem[0] !== 32'h01234567) $display("FAIL abort_mem got %h want 01234567", mem[0]); else passed++;
        rsp_ready = 1'b0;
        repeat (3) begin
            tick();
            total++; if (rsp_valid !== 1'b0) $display("FAIL abort_rsp got %b want 0", rsp_valid); else passed++;
        end
        total++; if (req_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", req_ready); else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        test_reset();
        test_sw();
        test_loads();
        test_subword_store();
        test_errors();
        test_stall();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
